// File: rtl/fetch_pack.sv
// fetch_pack: registers I-cache fetch packets into an issue-stage entry with slot enables.
// Define FETCH_PACK_SKID_EN to add a skid entry for full throughput with a registered ready.
module fetch_pack (
  input  logic         clk,
  input  logic         rst,
  input  logic         IC_valid_i,
  input  logic [127:0] IC_inst_p_i,
  input  logic [31:0]  IC_basePC_i,
  input  logic [3:0]   IC_predTake_p_i,
  input  logic [127:0] IC_predDest_p_i,
  input  logic         IC_hasException_i,
  input  logic [4:0]   IC_ExcCode_i,
  input  logic         IC_isRefill_i,
  output logic         IF_ready_o,
  input  logic         IS_stopFetch_i,
  input  logic         SBA_flush_w_i,
  input  logic         CP0_excOccur_w_i,
  output logic         IF_valid_o,
  output logic [127:0] IF_inst_p_o,
  output logic [127:0] IF_predDest_p_o,
  output logic [3:0]   IF_predTake_p_o,
  output logic [31:0]  IF_instBasePC_o,
  output logic [3:0]   IF_instEnable_o,
  output logic [2:0]   IF_instNum_o,
  output logic         IF_hasException_o,
  output logic [4:0]   IF_ExcCode_o,
  output logic         IF_isRefill_o
);
  typedef struct packed {
    logic [127:0] inst;
    logic [127:0] dest;
    logic [3:0]   take;
    logic [27:0]  pc;
    logic [3:0]   en;
    logic [2:0]   num;
    logic         exc;
    logic [4:0]   code;
    logic         refill;
  } pkt_t;
  logic       w_flush, w_cons, w_acc, w_load_out, w_ds_set, w_unused;
  logic [1:0] w_start, w_last;
  logic [3:0] w_smask, w_taken, w_en, w_take;
  logic [2:0] w_num;
  pkt_t       w_new, w_out_src;
  logic       r_out_v, r_ds;
  pkt_t       r_out;
  assign w_unused = ^IC_basePC_i[1:0];
  assign w_flush  = SBA_flush_w_i || CP0_excOccur_w_i;
  assign w_cons   = r_out_v && !IS_stopFetch_i && !w_flush;
  assign w_acc    = IC_valid_i && IF_ready_o && !w_flush;
  // The first taken slot keeps its delay slot; a taken slot 3 defers it to the next packet.
  always_comb begin
    w_start  = IC_basePC_i[3:2];
    w_smask  = 4'b1111 << w_start;
    w_taken  = IC_predTake_p_i & w_smask;
    w_last   = w_taken[0] ? 2'd1 : w_taken[1] ? 2'd2 : 2'd3;
    w_en     = r_ds ? 4'b0001 : IC_hasException_i ? 4'b0001 << w_start : w_smask & (4'b1111 >> (2'd3 - w_last));
    w_take   = (r_ds || IC_hasException_i) ? 4'b0000 : IC_predTake_p_i & w_en;
    w_num    = {2'b0, w_en[0]} + {2'b0, w_en[1]} + {2'b0, w_en[2]} + {2'b0, w_en[3]};
    w_ds_set = !r_ds && !IC_hasException_i && w_taken == 4'b1000;
    w_new    = {IC_inst_p_i, IC_predDest_p_i, w_take, IC_basePC_i[31:4], w_en, w_num,
                IC_hasException_i, IC_ExcCode_i, IC_isRefill_i};
  end
`ifdef FETCH_PACK_SKID_EN
  logic r_skid_v;
  pkt_t r_skid;
  assign IF_ready_o = !r_skid_v;
  assign w_load_out = (w_cons && r_skid_v) || (w_acc && (!r_out_v || w_cons));
  assign w_out_src  = r_skid_v ? r_skid : w_new;
  always_ff @(posedge clk) begin
    if (!rst)
      r_skid_v <= 1'b0;
    else
      r_skid_v <= !w_flush && !w_cons && (r_skid_v || (w_acc && r_out_v));
  end
  always_ff @(posedge clk)
    if (w_acc && r_out_v && !w_cons) r_skid <= w_new;
`else
  assign IF_ready_o = !r_out_v || IF_valid_o;
  assign w_load_out = w_acc;
  assign w_out_src  = w_new;
`endif
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_out_v     <= 1'b0;
      r_ds        <= 1'b0;
      r_out.en    <= 4'b0;
      r_out.num   <= 3'b0;
      r_out.exc   <= 1'b0;
    end else begin
      r_out_v <= !w_flush && (w_load_out || (r_out_v && !w_cons));
      r_ds    <= w_flush ? 1'b0 : w_acc ? w_ds_set : r_ds;
      if (w_load_out) r_out <= w_out_src;
    end
  end
  assign IF_valid_o        = w_cons;
  assign IF_inst_p_o       = r_out.inst;
  assign IF_predDest_p_o   = r_out.dest;
  assign IF_predTake_p_o   = r_out.take;
  assign IF_instBasePC_o   = {r_out.pc, 4'b0};
  assign IF_instEnable_o   = r_out.en;
  assign IF_instNum_o      = r_out.num;
  assign IF_hasException_o = r_out.exc;
  assign IF_ExcCode_o      = r_out.code;
  assign IF_isRefill_o     = r_out.refill;
endmodule

// File: tb/tb_fetch_pack.sv
// tb_fetch_pack: scoreboard bench for fetch_pack; expectations adapt to FETCH_PACK_SKID_EN.
module tb_fetch_pack;
`ifdef FETCH_PACK_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif
  typedef struct {
    logic [127:0] inst;
    logic [127:0] dest;
    logic [3:0]   take;
    logic [3:0]   en;
    logic [31:0]  pc;
    logic [2:0]   num;
    logic         exc;
    logic [4:0]   code;
    logic         refill;
  } exp_t;
  logic         clk = 1'b0, rst = 1'b0;
  logic         vld = 1'b0, exc = 1'b0, refill = 1'b0, stop = 1'b0, sba = 1'b0, cp0 = 1'b0;
  logic [127:0] inst = '0, pdest = '0;
  logic [31:0]  pc = '0;
  logic [3:0]   take = '0;
  logic [4:0]   code = '0;
  logic         IF_ready_o, IF_valid_o, IF_hasException_o, IF_isRefill_o;
  logic [127:0] IF_inst_p_o, IF_predDest_p_o;
  logic [3:0]   IF_predTake_p_o, IF_instEnable_o;
  logic [31:0]  IF_instBasePC_o;
  logic [2:0]   IF_instNum_o;
  logic [4:0]   IF_ExcCode_o;
  exp_t         q[$];
  bit           ds = 1'b0;
  int           tests = 0, fails = 0;

  fetch_pack dut (
    .clk(clk), .rst(rst), .IC_valid_i(vld), .IC_inst_p_i(inst), .IC_basePC_i(pc),
    .IC_predTake_p_i(take), .IC_predDest_p_i(pdest), .IC_hasException_i(exc),
    .IC_ExcCode_i(code), .IC_isRefill_i(refill), .IF_ready_o(IF_ready_o),
    .IS_stopFetch_i(stop), .SBA_flush_w_i(sba), .CP0_excOccur_w_i(cp0),
    .IF_valid_o(IF_valid_o), .IF_inst_p_o(IF_inst_p_o), .IF_predDest_p_o(IF_predDest_p_o),
    .IF_predTake_p_o(IF_predTake_p_o), .IF_instBasePC_o(IF_instBasePC_o),
    .IF_instEnable_o(IF_instEnable_o), .IF_instNum_o(IF_instNum_o),
    .IF_hasException_o(IF_hasException_o), .IF_ExcCode_o(IF_ExcCode_o), .IF_isRefill_o(IF_isRefill_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Walk slots from the start slot; stop after the first taken slot plus its delay slot.
  function automatic exp_t model(output bit nds);
    exp_t e;
    bit   done = 1'b0;
    int   s = int'(pc[3:2]);
    nds      = 1'b0;
    e.inst   = inst;
    e.dest   = pdest;
    e.pc     = {pc[31:4], 4'b0};
    e.exc    = exc;
    e.code   = code;
    e.refill = refill;
    e.en     = 4'b0;
    if (ds) e.en = 4'b0001;
    else if (exc) e.en[s] = 1'b1;
    else
      for (int j = s; j < 4 && !done; j++) begin
        e.en[j] = 1'b1;
        if (take[j]) begin
          done = 1'b1;
          if (j < 3) e.en[j+1] = 1'b1;
          else nds = 1'b1;
        end
      end
    e.take = (ds || exc) ? 4'b0 : take & e.en;
    e.num  = 3'd0;
    for (int j = 0; j < 4; j++) e.num = e.num + {2'b0, e.en[j]};
    return e;
  endfunction

  task automatic set_pkt(input logic v, input logic [31:0] p, input logic [3:0] t,
                         input logic x, input logic [4:0] c);
    vld    = v;
    pc     = p;
    take   = t;
    exc    = x;
    code   = c;
    refill = 1'($urandom_range(0, 1));
    inst   = {$urandom, $urandom, $urandom, $urandom};
    pdest  = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic step();
    bit   vexp, rexp, acc, fl, nds;
    exp_t e;
    logic [49:0] ca, ce;
    #1;
    fl   = sba || cp0;
    vexp = q.size() > 0 && !stop && !fl;
    rexp = SKID ? q.size() < 2 : (q.size() == 0 || vexp);
    acc  = vld && rexp && !fl;
    tests++;
    if (IF_ready_o !== rexp) begin
      fails++;
      $display("FAIL ready: got %b want %b", IF_ready_o, rexp);
    end
    tests++;
    if (IF_valid_o !== vexp) begin
      fails++;
      $display("FAIL valid: got %b want %b", IF_valid_o, vexp);
    end
    if (vexp) begin
      e  = q.pop_front();
      ca = {IF_instEnable_o, IF_instNum_o, IF_predTake_p_o, IF_instBasePC_o, IF_hasException_o,
            e.exc ? {IF_ExcCode_o, IF_isRefill_o} : 6'b0};
      ce = {e.en, e.num, e.take, e.pc, e.exc, e.exc ? {e.code, e.refill} : 6'b0};
      tests++;
      if (ca !== ce) begin
        fails++;
        $display("FAIL pkt_ctl: got %h want %h", ca, ce);
      end
      tests++;
      if ({IF_inst_p_o, IF_predDest_p_o} !== {e.inst, e.dest}) begin
        fails++;
        $display("FAIL pkt_data: got %h want %h", {IF_inst_p_o, IF_predDest_p_o}, {e.inst, e.dest});
      end
    end
    if (fl) begin
      q.delete();
      ds = 1'b0;
    end else if (acc) begin
      e = model(nds);
      q.push_back(e);
      ds = nds;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_out(input string name, input logic [3:0] en, input logic [2:0] num,
                           input logic [3:0] tk);
    tests++;
    if ({IF_instEnable_o, IF_instNum_o, IF_predTake_p_o} !== {en, num, tk}) begin
      fails++;
      $display("FAIL %s: got en=%b num=%0d take=%b want en=%b num=%0d take=%b",
               name, IF_instEnable_o, IF_instNum_o, IF_predTake_p_o, en, num, tk);
    end
  endtask

  task automatic apply_reset(input string name);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    q.delete();
    ds = 1'b0;
    tests++;
    if ({IF_valid_o, IF_ready_o, IF_instEnable_o, IF_instNum_o, IF_hasException_o} !== {1'b0, 1'b1, 4'b0, 3'b0, 1'b0}) begin
      fails++;
      $display("FAIL %s: got valid=%b ready=%b en=%b num=%0d exc=%b want 0 1 0000 0 0",
               name, IF_valid_o, IF_ready_o, IF_instEnable_o, IF_instNum_o, IF_hasException_o);
    end
    rst = 1'b1;
  endtask

  task automatic idle();
    set_pkt(1'b0, 32'h0, 4'b0, 1'b0, 5'h0);
    stop = 1'b0;
    sba  = 1'b0;
    cp0  = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    @(negedge clk);
    apply_reset("reset_state");
    step();
  endtask

  task automatic test_basic();
    set_pkt(1'b1, 32'h1FC00008, 4'b0000, 1'b0, 5'h0);
    step();
    tests++;
    if (IF_instBasePC_o !== 32'h1FC00000) begin
      fails++;
      $display("FAIL basic_pc: got %h want 1fc00000", IF_instBasePC_o);
    end
    check_out("basic_en", 4'b1100, 3'd2, 4'b0000);
    idle();
    step();
  endtask

  task automatic test_pred();
    set_pkt(1'b1, 32'h80000000, 4'b0010, 1'b0, 5'h0);
    step();
    check_out("pred_k1", 4'b0111, 3'd3, 4'b0010);
    set_pkt(1'b1, 32'h80000000, 4'b1000, 1'b0, 5'h0);
    step();
    check_out("pred_k3", 4'b1111, 3'd4, 4'b1000);
    set_pkt(1'b1, 32'h80000008, 4'b0100, 1'b0, 5'h0);
    step();
    check_out("pred_ds", 4'b0001, 3'd1, 4'b0000);
    idle();
    step();
  endtask

  task automatic test_exc();
    set_pkt(1'b1, 32'h80000006, 4'b1111, 1'b1, 5'h04);
    step();
    check_out("exc_en", 4'b0010, 3'd1, 4'b0000);
    tests++;
    if ({IF_hasException_o, IF_ExcCode_o} !== {1'b1, 5'h04}) begin
      fails++;
      $display("FAIL exc_code: got exc=%b code=%h want 1 04", IF_hasException_o, IF_ExcCode_o);
    end
    idle();
    step();
  endtask

  task automatic test_stall();
    stop = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_pkt(1'b1, 32'h80001000 + 32'(i * 16), 4'b0000, 1'b0, 5'h0);
      step();
    end
    #1;
    tests++;
    if ({IF_ready_o, IF_valid_o} !== 2'b00) begin
      fails++;
      $display("FAIL stall_full: got ready=%b valid=%b want 0 0", IF_ready_o, IF_valid_o);
    end
    idle();
    for (int i = 0; i < 3; i++) step();
  endtask

  task automatic test_flush();
    stop = 1'b1;
    set_pkt(1'b1, 32'h80002000, 4'b0000, 1'b0, 5'h0);
    step();
    set_pkt(1'b1, 32'h80002010, 4'b1000, 1'b0, 5'h0);
    step();
    sba = 1'b1;
    set_pkt(1'b1, 32'h80002020, 4'b0000, 1'b0, 5'h0);
    step();
    idle();
    step();
    set_pkt(1'b1, 32'h80002038, 4'b0000, 1'b0, 5'h0);
    step();
    check_out("flush_ds_clear", 4'b1100, 3'd2, 4'b0000);
    idle();
    step();
  endtask

  task automatic test_reset_mid();
    stop = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_pkt(1'b1, 32'h80003000 + 32'(i * 16), 4'b1000, 1'b0, 5'h0);
      step();
    end
    apply_reset("reset_mid");
    idle();
    for (int i = 0; i < 3; i++) step();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 300; i++) begin
      set_pkt(1'($urandom_range(0, 3) != 0), $urandom, 4'($urandom_range(0, 15)),
              1'($urandom_range(0, 7) == 0), 5'($urandom_range(0, 31)));
      stop = 1'($urandom_range(0, 3) == 0);
      sba  = 1'($urandom_range(0, 19) == 0);
      cp0  = 1'($urandom_range(0, 29) == 0);
      step();
    end
    idle();
    for (int i = 0; i < 4; i++) step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pred();
    test_exc();
    test_stall();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fetch_pack.md
FETCH_PACK -- requirements
Module: fetch_pack

Interface
REQ-001 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst  in  1  reset, synchronous, active-low.
REQ-003 SHALL have ports IC_valid_i in 1 (cache packet valid); IC_inst_p_i in 128 (four words, slot0 at [31:0]); IC_basePC_i in 32 (fetch PC); IC_predTake_p_i in 4; IC_predDest_p_i in 128.
REQ-004 SHALL have ports IC_hasException_i in 1; IC_ExcCode_i in 5; IC_isRefill_i in 1.
REQ-005 SHALL have ports IF_ready_o out 1 (packet accepted when IC_valid_i&&IF_ready_o); IS_stopFetch_i in 1; SBA_flush_w_i in 1; CP0_excOccur_w_i in 1.
REQ-006 SHALL have outputs to issue stage: IF_valid_o 1, IF_inst_p_o 128, IF_predDest_p_o 128, IF_predTake_p_o 4, IF_instBasePC_o 32, IF_instEnable_o 4, IF_instNum_o 3, IF_hasException_o 1, IF_ExcCode_o 5, IF_isRefill_o 1.

Function
REQ-007 SHALL hold a registered output entry (out) and, when configured, one skid entry; all packet outputs driven directly from out.
REQ-008 SHALL present IF_valid_o = out_valid && !IS_stopFetch_i && !flush, flush = SBA_flush_w_i||CP0_excOccur_w_i; out consumed in any cycle IF_valid_o=1.
REQ-009 SHALL compute, at accept, start = IC_basePC_i[3:2]; IF_instBasePC_o = {IC_basePC_i[31:4],4'b0}.
REQ-010 SHALL enable slots start..last, last = 3, or k+1 where k is lowest enabled slot with IC_predTake_p_i[k]=1 (delay slot kept), saturating at 3.
REQ-011 SHALL set ds_pending when k=3; next accepted packet then has enable 4'b0001 regardless of start, IF_predTake_p_o masked to 0, ds_pending cleared.
REQ-012 SHALL, when IC_hasException_i=1, enable only slot start, pass ExcCode/isRefill, ignore predictions, not set ds_pending.
REQ-013 SHALL set IF_instNum_o = popcount(IF_instEnable_o), range 1..4; IF_predTake_p_o zeroed on disabled slots.
REQ-014 SHALL accept into out when out empty or consumed this cycle and skid empty; otherwise into skid; skid moves to out when out consumed; order preserved.
REQ-015 SHALL drive IF_ready_o = !skid_valid (skid configured); never accept while skid full.
REQ-016 SHALL, on flush, clear out_valid, skid_valid, ds_pending next cycle, drop any packet offered that cycle, force IF_valid_o=0 that cycle; IF_ready_o unaffected.
REQ-017 SHALL treat IS_stopFetch_i as stall only: out/skid held unchanged, no data loss.

Reset
REQ-018 SHALL, when rst=0 at a clock edge, clear out_valid, skid_valid, ds_pending; IF_valid_o=0, IF_instEnable_o=0, IF_instNum_o=0, IF_hasException_o=0 next cycle; reset overrides flush and accept.
REQ-019 SHALL leave data fields unreset; IF_ready_o=1 from first cycle after reset.

Configuration
REQ-020 SHALL compile skid entry only when FETCH_PACK_SKID_EN is defined; throughput one packet/cycle under continuous consumption.
REQ-021 SHALL, without FETCH_PACK_SKID_EN, have out only, IF_ready_o = !out_valid || IF_valid_o (combinational path from IS_stopFetch_i); all other REQs unchanged.

Verification
REQ-022 SHALL test: PC=0x1FC00008, no predTake -> IF_instBasePC_o=0x1FC00000, enable=4'b1100, instNum=2, one cycle later.
REQ-023 SHALL test: PC=0x80000000, predTake=4'b0010 -> enable=4'b0111, instNum=3; then predTake=4'b1000 packet -> next packet enable=4'b0001, predTake=0.
REQ-024 SHALL test: IS_stopFetch_i high 5 cycles with IC_valid_i continuous (SKID_EN) -> IF_ready_o low after 2 accepts, IF_valid_o=0; release -> both packets delivered in order, no loss.
REQ-025 SHALL test: SBA_flush_w_i pulse with out and skid full and IC_valid_i=1 -> IF_valid_o=0 that cycle, nothing delivered next cycle, ds_pending cleared.
REQ-026 SHALL test: IC_hasException_i=1, ExcCode=5'h04, PC=0x80000006 -> enable=4'b0010, instNum=1, IF_hasException_o=1, IF_ExcCode_o=5'h04.
REQ-027 SHALL test: rst=0 asserted mid-stall with both entries full -> next cycle IF_valid_o=0, IF_ready_o=1, no stale packet after rst=1.
